// File: rtl/s_to_p_frame_if.sv
// Handshake bundle for s_to_p_frame: serial bit input side plus parallel frame output side.
// Port set grows by i_flush/o_partial when S2P_FLUSH_EN is defined.
interface s_to_p_frame_if #(
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 8
);
  logic                      i_data;
  logic                      i_valid;
  logic                      i_ready;
  logic                      i_msb_first;
  logic [IWIDTH*OWIDTH-1:0]  o_data;
  logic                      o_valid;
  logic                      o_ready;
`ifdef S2P_FLUSH_EN
  logic                      i_flush;
  logic                      o_partial;

  modport slave (
    input  i_data, i_valid, i_msb_first, o_ready, i_flush,
    output i_ready, o_data, o_valid, o_partial
  );
  modport master (
    output i_data, i_valid, i_msb_first, o_ready, i_flush,
    input  i_ready, o_data, o_valid, o_partial
  );
`else
  modport slave (
    input  i_data, i_valid, i_msb_first, o_ready,
    output i_ready, o_data, o_valid
  );
  modport master (
    output i_data, i_valid, i_msb_first, o_ready,
    input  i_ready, o_data, o_valid
  );
`endif
endinterface

// File: rtl/s_to_p_frame.sv
// Serial-to-parallel framer: packs 1-bit stream into OWIDTH symbols of IWIDTH bits each.
// Optional early-completion flush enabled with S2P_FLUSH_EN.
//
//   state | meaning
//   FILL  | accepting bits into the assembly register (i_ready=1)
//   HOLD  | assembled frame waiting for the output register to free up (i_ready=0)
module s_to_p_frame #(
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  s_to_p_frame_if.slave bus
);
  localparam int W  = IWIDTH * OWIDTH;
  localparam int BW = (IWIDTH > 1) ? $clog2(IWIDTH) : 1;
  localparam int SW = (OWIDTH > 1) ? $clog2(OWIDTH) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(IWIDTH - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OWIDTH - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state;
  logic [W-1:0]  asm_q;
  logic [W-1:0]  frame_next;
  logic [BW-1:0] b_ctr;
  logic [SW-1:0] s_ctr;
  logic          msb_q;
  logic          accept;
  logic          first;
  logic          order;
  logic          last_bit;
  logic          flush_go;
  logic          done;
  logic          slot_free;
`ifdef S2P_FLUSH_EN
  logic          part_pend;
`endif

  assign bus.i_ready = (state == FILL);

  always_comb begin
    accept     = bus.i_valid && (state == FILL);
    first      = (b_ctr == '0) && (s_ctr == '0);
    // order is live-sampled on the first bit of a frame, latched thereafter
    order      = first ? bus.i_msb_first : msb_q;
    frame_next = asm_q;
    if (accept) begin
      for (int s = 0; s < OWIDTH; s++) begin
        for (int k = 0; k < IWIDTH; k++) begin
          if ((s_ctr == SW'(s)) && (b_ctr == BW'(k))) begin
            if (order) frame_next[s*IWIDTH + IWIDTH-1-k] = bus.i_data;
            else       frame_next[s*IWIDTH + k]          = bus.i_data;
          end
        end
      end
    end
    last_bit  = accept && (b_ctr == B_LAST) && (s_ctr == S_LAST);
`ifdef S2P_FLUSH_EN
    flush_go  = (state == FILL) && bus.i_flush && (accept || !first);
`else
    flush_go  = 1'b0;
`endif
    done      = last_bit || flush_go;
    slot_free = !bus.o_valid || bus.o_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= FILL;
      asm_q         <= '0;
      b_ctr         <= '0;
      s_ctr         <= '0;
      msb_q         <= 1'b0;
      bus.o_data    <= '0;
      bus.o_valid   <= 1'b0;
`ifdef S2P_FLUSH_EN
      bus.o_partial <= 1'b0;
      part_pend     <= 1'b0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (done) begin
            b_ctr <= '0;
            s_ctr <= '0;
            msb_q <= 1'b0;
            if (slot_free) begin
              bus.o_data    <= frame_next;
              bus.o_valid   <= 1'b1;
              asm_q         <= '0;
`ifdef S2P_FLUSH_EN
              bus.o_partial <= !last_bit;
`endif
            end else begin
              asm_q     <= frame_next;
`ifdef S2P_FLUSH_EN
              part_pend <= !last_bit;
`endif
              state     <= HOLD;
            end
          end else begin
            if (accept) begin
              asm_q <= frame_next;
              if (first) msb_q <= bus.i_msb_first;
              if (b_ctr == B_LAST) begin
                b_ctr <= '0;
                s_ctr <= s_ctr + SW'(1);
              end else begin
                b_ctr <= b_ctr + BW'(1);
              end
            end
            if (bus.o_valid && bus.o_ready) bus.o_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (bus.o_ready) begin
            bus.o_data    <= asm_q;
            bus.o_valid   <= 1'b1;
`ifdef S2P_FLUSH_EN
            bus.o_partial <= part_pend;
`endif
            asm_q         <= '0;
            state         <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_s_to_p_frame.sv
// Directed bench for s_to_p_frame (IWIDTH=8, OWIDTH=8); flush vectors run when S2P_FLUSH_EN is defined.
module tb_s_to_p_frame;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  localparam logic [63:0] F1     = 64'h0807060504030201;
  localparam logic [63:0] F1_MSB = 64'h10E060A020C04080;
  localparam logic [63:0] FB     = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] F2     = 64'h123456789ABCDEF0;

  s_to_p_frame_if #(.IWIDTH(8), .OWIDTH(8)) bus ();

  s_to_p_frame #(.IWIDTH(8), .OWIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sends bits[0..63] one per clock; i_msb_first switches to 1 from bit index tog onward
  task automatic send_frame(input logic [63:0] bits, input logic msb, input int tog);
    for (int n = 0; n < 64; n++) begin
      bus.i_valid     = 1'b1;
      bus.i_data      = bits[n];
      bus.i_msb_first = (n >= tog) ? 1'b1 : msb;
      tick();
    end
    bus.i_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] pre;
    n_chk = 0;
    n_err = 0;
    rst             = 1'b0;
    bus.i_data      = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_msb_first = 1'b0;
    bus.o_ready     = 1'b1;
`ifdef S2P_FLUSH_EN
    bus.i_flush     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_o_data", bus.o_data, 64'd0);
    chk("rst_i_ready", 64'(bus.i_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    // 1: LSB-first frame, single-cycle o_valid
    send_frame(F1, 1'b0, 64);
    chk("t1_o_valid", 64'(bus.o_valid), 64'd1);
    chk("t1_o_data", bus.o_data, F1);
    tick();
    chk("t1_o_valid_drop", 64'(bus.o_valid), 64'd0);
    chk("t1_o_data_hold", bus.o_data, F1);

    // 2: MSB-first frame
    send_frame(F1, 1'b1, 64);
    chk("t2_o_valid", 64'(bus.o_valid), 64'd1);
    chk("t2_o_data", bus.o_data, F1_MSB);
    tick();
    chk("t2_o_valid_drop", 64'(bus.o_valid), 64'd0);

    // 3: backpressure, HOLD, dropped bits, release
    bus.o_ready = 1'b0;
    send_frame(F1, 1'b0, 64);
    chk("t3_a_valid", 64'(bus.o_valid), 64'd1);
    chk("t3_a_data", bus.o_data, F1);
    chk("t3_a_i_ready", 64'(bus.i_ready), 64'd1);
    send_frame(FB, 1'b0, 64);
    chk("t3_hold_i_ready", 64'(bus.i_ready), 64'd0);
    chk("t3_hold_data", bus.o_data, F1);
    chk("t3_hold_valid", 64'(bus.o_valid), 64'd1);
    bus.i_valid = 1'b1;
    bus.i_data  = 1'b1;
    repeat (5) tick();
    bus.i_valid = 1'b0;
    chk("t3_drop_data", bus.o_data, F1);
    chk("t3_drop_i_ready", 64'(bus.i_ready), 64'd0);
    bus.o_ready = 1'b1;
    tick();
    bus.o_ready = 1'b0;
    chk("t3_b_data", bus.o_data, FB);
    chk("t3_b_valid", 64'(bus.o_valid), 64'd1);
    chk("t3_b_i_ready", 64'(bus.i_ready), 64'd1);
    tick();
    chk("t3_b_stable", 64'(bus.o_valid), 64'd1);
    bus.o_ready = 1'b1;
    tick();
    chk("t3_b_valid_drop", 64'(bus.o_valid), 64'd0);
    chk("t3_b_data_hold", bus.o_data, FB);

    // 4: async reset mid-frame, then a clean frame
    for (int n = 0; n < 13; n++) begin
      bus.i_valid     = 1'b1;
      bus.i_data      = FB[n];
      bus.i_msb_first = 1'b1;
      tick();
    end
    bus.i_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("t4_rst_valid", 64'(bus.o_valid), 64'd0);
    chk("t4_rst_data", bus.o_data, 64'd0);
    chk("t4_rst_i_ready", 64'(bus.i_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    send_frame(F1, 1'b0, 64);
    chk("t4_clean_valid", 64'(bus.o_valid), 64'd1);
    chk("t4_clean_data", bus.o_data, F1);

    // 5: order change mid-frame takes effect on the following back-to-back frame
    send_frame(F2, 1'b0, 20);
    chk("t5_lsb_valid", 64'(bus.o_valid), 64'd1);
    chk("t5_lsb_data", bus.o_data, F2);
    pre = bus.o_data;
    bus.i_valid     = 1'b1;
    bus.i_data      = F1[0];
    bus.i_msb_first = 1'b1;
    tick();
    chk("t5_gap_valid", 64'(bus.o_valid), 64'd0);
    chk("t5_gap_data", bus.o_data, pre);
    for (int n = 1; n < 64; n++) begin
      bus.i_data = F1[n];
      tick();
    end
    bus.i_valid = 1'b0;
    chk("t5_msb_valid", 64'(bus.o_valid), 64'd1);
    chk("t5_msb_data", bus.o_data, F1_MSB);
    tick();

`ifdef S2P_FLUSH_EN
    // 6: partial frame via flush
    bus.i_msb_first = 1'b0;
    for (int n = 0; n < 12; n++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 1'b1;
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("t6_flush_valid", 64'(bus.o_valid), 64'd1);
    chk("t6_flush_data", bus.o_data, 64'h0000000000000FFF);
    chk("t6_flush_partial", 64'(bus.o_partial), 64'd1);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("t6_empty_valid", 64'(bus.o_valid), 64'd0);
    tick();
    chk("t6_empty_valid2", 64'(bus.o_valid), 64'd0);
    send_frame(F1, 1'b0, 64);
    chk("t6_full_data", bus.o_data, F1);
    chk("t6_full_partial", 64'(bus.o_partial), 64'd0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
